intersect_seq_monitor: RTL
==========================

Name: intersect_seq_monitor

Overview:
- Synthesizable, multi-channel hardware monitor for the property "trigger |-> (##[A_MIN:A_MAX] a) intersect (b ##[S_MIN:S_MAX] stop)".
- Each channel tracks every concurrent attempt, like SVA threads, and reports pass/fail per attempt.
- Sits beside protocol blocks as an on-chip checker. Results also feed debug counters readable by the host.

Parameters:
- NCH, 4, number of independent channels
- A_MIN, 1, lower delay bound of s1 (a), must be >=1
- A_MAX, 2, upper delay bound of s1, must be >=A_MIN
- S_MIN, 2, lower delay bound from b to stop, must be >=1
- S_MAX, 3, upper delay bound from b to stop, must be >=S_MIN
- NONOVL, 1, 1 selects |=> (anchor one cycle after trigger); 0 selects |-> (anchor on the trigger cycle)
- CNT_W, 16, width of each saturating pass/fail counter

Ports:
- clk  in  1  clock; all sampling on posedge
- rst_n  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear of pending attempts and counters
- start_i  in  NCH  per-channel start; a rising edge ($rose) is the trigger
- a_i  in  NCH  per-channel signal a
- b_i  in  NCH  per-channel signal b
- stop_i  in  NCH  per-channel signal stop
- pass_o  out  NCH  one-cycle pulse: at least one attempt passed
- fail_o  out  NCH  one-cycle pulse: at least one attempt failed
- busy_o  out  NCH  at least one attempt pending
- pass_cnt_o  out  NCH*CNT_W  saturating pass counters, channel c at [c*CNT_W +: CNT_W]
- fail_cnt_o  out  NCH*CNT_W  saturating fail counters, same packing
- last_len_o  out  NCH*8  length of the most recent passing match (see Optional Feature)

Behaviour:
- Window: L = max(A_MIN,S_MIN), H = min(A_MAX,S_MAX). If L>H, elaboration fails ($error). Defaults give L=H=2.
- Trigger: start_i & ~start_q. start_q is reset to 0, so start high on the first cycle after reset counts as a rise. start_q is not affected by clear_i.
- Anchor: when NONOVL=1, anchor = trigger delayed one cycle through a register. When NONOVL=0, anchor = trigger.
- Per channel, a pending vector pend[1..H]. pend[k]=1 means an attempt anchored k cycles ago is unresolved.
- Evaluation each cycle, per channel:
  - anchor & ~b: fail (this attempt).
  - anchor & b: set pend[1] for the next cycle.
  - For each k with pend[k]=1:
    - k in [L,H] and a & stop: pass, attempt retired.
    - else k==H: fail.
    - else: shift to pend[k+1].
- Attempts are independent. A retrigger while busy spawns a new thread. Several attempts may resolve in the same cycle.
- Latency: pass_o/fail_o are registered and assert the cycle after the evaluation cycle. Both may assert together if different attempts resolve differently.
- Counters: each counter adds the number of attempts resolved that cycle (popcount) and saturates at 2^CNT_W-1.
- busy_o is combinational from |pend, or from a registered anchor still waiting in NONOVL=1 mode.
- Reset: asynchronous. pend, anchor register, start_q, pass_o, fail_o, counters and last_len_o all go to 0. Attempts in flight are discarded silently.
- clear_i: the next state is the reset state, except start_q. It takes priority over evaluation in that cycle, and no pulses are emitted for discarded attempts.

Optional Feature:
- Macro: INTERSECT_SEQ_MONITOR_LEN_EN.
- Defined: last_len_o[c] loads the age k of the passing attempt on each pass. If several attempts pass in one cycle, it loads the largest k (the oldest attempt).
- Undefined: last_len_o is tied to 0 and no length logic is built.

Test Plan:
- Defaults, ch0: start rises, sampled at cycle 0. b=1 at cycle 1; a=stop=1 at cycle 3 -> pass_o[0]=1 at cycle 4 only, pass_cnt[0]=1, busy_o[0] low from cycle 4, last_len=2 (macro on).
- Defaults: rise at cycle 0, b=0 at cycle 1 -> fail_o[0]=1 at cycle 2, fail_cnt=1, no pass.
- Defaults: rise at 0, b=1 at 1; a=1, stop=0 at cycle 3 -> fail_o at cycle 4. Channel 1 driven identically in parallel with stop=1 -> pass_o[1] at cycle 4, so channels are independent.
- Overlap, NONOVL=0: start 1,0,1 at cycles 0-2, b=1 at 0 and 2; a=stop=1 at 2 and 4 -> pass_o at cycles 3 and 5, pass_cnt=2. The cycle-2 anchor is not lost.
- rst_n low at cycle 2 of a pending attempt, released at cycle 3 -> all outputs 0 during reset and no pass/fail later. The same sequence using clear_i gives the same result.
- CNT_W=2: six passing attempts -> pass_cnt_o saturates at 3. A subsequent clear_i -> 0.

Source files
------------

// File: rtl/intersect_seq_monitor.sv
// intersect_seq_monitor: multi-channel checker for
//   trigger |-> (##[A_MIN:A_MAX] a) intersect (b ##[S_MIN:S_MAX] stop)
// Every attempt is tracked as its own thread in a per-channel pending vector
// indexed by attempt age. Pass/fail pulses are registered, and the debug
// counters saturate.
// Optional feature macro: INTERSECT_SEQ_MONITOR_LEN_EN (enables last_len_o).
module intersect_seq_monitor #(
    parameter int NCH    = 4,
    parameter int A_MIN  = 1,
    parameter int A_MAX  = 2,
    parameter int S_MIN  = 2,
    parameter int S_MAX  = 3,
    parameter int NONOVL = 1,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic [NCH-1:0]     start_i,
    input  logic [NCH-1:0]     a_i,
    input  logic [NCH-1:0]     b_i,
    input  logic [NCH-1:0]     stop_i,
    output logic [NCH-1:0]     pass_o,
    output logic [NCH-1:0]     fail_o,
    output logic [NCH-1:0]     busy_o,
    output logic [NCH*CNT_W-1:0] pass_cnt_o,
    output logic [NCH*CNT_W-1:0] fail_cnt_o,
    output logic [NCH*8-1:0]   last_len_o
);

    // The match window is the overlap of the a-delay range and the b-to-stop
    // range, because a and stop must land on the same cycle.
    localparam int L = (A_MIN > S_MIN) ? A_MIN : S_MIN;
    localparam int H = (A_MAX < S_MAX) ? A_MAX : S_MAX;

    if (L > H) begin : g_badWindow
        $error("intersect_seq_monitor: empty window, max(A_MIN,S_MIN) > min(A_MAX,S_MAX)");
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic             r_startQ;
        logic             r_anchorQ;
        logic             r_pass;
        logic             r_fail;
        logic [H:1]       r_pend;
        logic [CNT_W-1:0] r_passCnt;
        logic [CNT_W-1:0] r_failCnt;

        logic             w_trig;
        logic             w_anchor;
        logic             w_hit;
        logic [H:1]       w_pendNext;
        logic [7:0]       w_passNum;
        logic [7:0]       w_failNum;
        logic [CNT_W+7:0] w_passSum;
        logic [CNT_W+7:0] w_failSum;
`ifdef INTERSECT_SEQ_MONITOR_LEN_EN
        logic [7:0]       r_lastLen;
        logic [7:0]       w_lenNext;
`endif

        assign w_trig   = start_i[c] & ~r_startQ;
        assign w_anchor = (NONOVL != 0) ? r_anchorQ : w_trig;
        assign w_hit    = a_i[c] & stop_i[c];

        // Resolve every pending thread this cycle: count passes and fails and
        // age the survivors by one slot.
        always_comb begin
            w_passNum     = 8'd0;
            w_pendNext    = '0;
            w_pendNext[1] = w_anchor & b_i[c];
`ifdef INTERSECT_SEQ_MONITOR_LEN_EN
            w_lenNext     = 8'd0;
`endif
            for (int k = L; k <= H; k++) begin
                if (r_pend[k] && w_hit) begin
                    w_passNum = w_passNum + 8'd1;
`ifdef INTERSECT_SEQ_MONITOR_LEN_EN
                    w_lenNext = 8'(k);
`endif
                end
            end
            for (int k = 2; k <= H; k++) begin
                w_pendNext[k] = r_pend[k-1] & ~(((k - 1) >= L) && w_hit);
            end
            w_failNum = {7'd0, w_anchor & ~b_i[c]} + {7'd0, r_pend[H] & ~w_hit};
            w_passSum = {8'd0, r_passCnt} + {{CNT_W{1'b0}}, w_passNum};
            w_failSum = {8'd0, r_failCnt} + {{CNT_W{1'b0}}, w_failNum};
        end

        // Edge-detect history for the trigger; clear_i does not touch it, so a
        // level held across a clear does not re-trigger.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_startQ <= 1'b0;
            end else begin
                r_startQ <= start_i[c];
            end
        end

        // Thread state, result pulses and saturating counters.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_anchorQ <= 1'b0;
                r_pend    <= '0;
                r_pass    <= 1'b0;
                r_fail    <= 1'b0;
                r_passCnt <= '0;
                r_failCnt <= '0;
            end else if (clear_i) begin
                r_anchorQ <= 1'b0;
                r_pend    <= '0;
                r_pass    <= 1'b0;
                r_fail    <= 1'b0;
                r_passCnt <= '0;
                r_failCnt <= '0;
            end else begin
                r_anchorQ <= (NONOVL != 0) ? w_trig : 1'b0;
                r_pend    <= w_pendNext;
                r_pass    <= (w_passNum != 8'd0);
                r_fail    <= (w_failNum != 8'd0);
                if (w_passSum[CNT_W+7:CNT_W] != 8'd0) begin
                    r_passCnt <= '1;
                end else begin
                    r_passCnt <= w_passSum[CNT_W-1:0];
                end
                if (w_failSum[CNT_W+7:CNT_W] != 8'd0) begin
                    r_failCnt <= '1;
                end else begin
                    r_failCnt <= w_failSum[CNT_W-1:0];
                end
            end
        end

`ifdef INTERSECT_SEQ_MONITOR_LEN_EN
        // Capture the age of the oldest attempt that passed this cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_lastLen <= 8'd0;
            end else if (clear_i) begin
                r_lastLen <= 8'd0;
            end else if (w_passNum != 8'd0) begin
                r_lastLen <= w_lenNext;
            end
        end
        assign last_len_o[c*8 +: 8] = r_lastLen;
`else
        assign last_len_o[c*8 +: 8] = 8'd0;
`endif

        assign pass_o[c]                  = r_pass;
        assign fail_o[c]                  = r_fail;
        assign busy_o[c]                  = (|r_pend) | r_anchorQ;
        assign pass_cnt_o[c*CNT_W +: CNT_W] = r_passCnt;
        assign fail_cnt_o[c*CNT_W +: CNT_W] = r_failCnt;
    end

endmodule
